// File: rtl/reg_file_sb_pkg.sv
// Shared defaults and helpers for the scoreboarded register file.
package reg_file_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 4;

  // The highest address is reserved for the program counter.
  function automatic int pc_addr(input int addr_w);
    return (1 << addr_w) - 1;
  endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Register-file bus: two read ports, one write-back port, an issue port and
// the pending-count status.
//
// Handshake: there is no valid/ready flow control on this bus. we3 and iss
// are single-cycle strobes; they are sampled on every rising clock edge and
// always accepted. Read data and busy flags are combinational and valid in
// the same cycle as the read address.
interface reg_file_sb_if
  import reg_file_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);

  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              rb1;
  logic              rb2;
  logic              we3;
  logic [ADDR_W-1:0] wa3;
  logic [DATA_W-1:0] wd3;
  logic [DATA_W-1:0] r15;
  logic              iss;
  logic [ADDR_W-1:0] isa;
  logic [ADDR_W:0]   pend_cnt;

  // Pipeline side: issues, writes back and reads.
  modport master (
    output ra1, ra2, we3, wa3, wd3, r15, iss, isa,
    input  rd1, rd2, rb1, rb2, pend_cnt
  );

  // Register file side.
  modport slave (
    input  ra1, ra2, we3, wa3, wd3, r15, iss, isa,
    output rd1, rd2, rb1, rb2, pend_cnt
  );

endinterface

// File: rtl/reg_file_sb_scoreboard.sv
// Busy-bit scoreboard: tracks registers with an outstanding write and keeps a
// registered count of them.
module reg_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int PC_ADDR = pc_addr(ADDR_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_set_en,
  input  logic [ADDR_W-1:0] i_set_addr,
  input  logic              i_clr_en,
  input  logic [ADDR_W-1:0] i_clr_addr,
  input  logic [ADDR_W-1:0] i_ra1,
  input  logic [ADDR_W-1:0] i_ra2,
  output logic              o_rb1,
  output logic              o_rb2,
  output logic [ADDR_W:0]   o_pend_cnt
);

  localparam int                NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LP_PC    = ADDR_W'(PC_ADDR);

  logic [NUM_REGS-1:0] r_busy;
  logic [NUM_REGS-1:0] w_busy_nxt;
  logic [ADDR_W:0]     r_pend_cnt;
  logic [ADDR_W:0]     w_pend_nxt;
  logic                w_clr_hit1;
  logic                w_clr_hit2;

  // Next busy vector: clear on write-back, then set on issue so a same-cycle
  // issue to the written register keeps it busy. The PC slot is never busy,
  // which bounds the count at NUM_REGS-1.
  always_comb begin
    w_busy_nxt = r_busy;
    if (i_clr_en && (i_clr_addr != LP_PC)) w_busy_nxt[i_clr_addr] = 1'b0;
    if (i_set_en && (i_set_addr != LP_PC)) w_busy_nxt[i_set_addr] = 1'b1;
  end

  // Popcount of the next busy vector so the count lands on the same edge.
  always_comb begin
    w_pend_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_pend_nxt = w_pend_nxt + (ADDR_W+1)'(w_busy_nxt[i]);
    end
  end

  // Busy vector and count registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_pend_cnt <= '0;
    end else begin
      r_busy     <= w_busy_nxt;
      r_pend_cnt <= w_pend_nxt;
    end
  end

  // A write-back this cycle to the read register supplies its data through
  // the bypass, so the reader sees it as no longer busy.
  assign w_clr_hit1 = i_clr_en && (i_clr_addr == i_ra1);
  assign w_clr_hit2 = i_clr_en && (i_clr_addr == i_ra2);

  assign o_rb1      = (i_ra1 != LP_PC) && r_busy[i_ra1] && !w_clr_hit1;
  assign o_rb2      = (i_ra2 != LP_PC) && r_busy[i_ra2] && !w_clr_hit2;
  assign o_pend_cnt = r_pend_cnt;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with PC read-through, write-through bypass and a busy-bit
// scoreboard for outstanding writes.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int PC_ADDR = pc_addr(ADDR_W)
) (
  input  logic          clk,
  input  logic          rst_n,
  reg_file_sb_if.slave  bus
);

  localparam int                NUM_REGS = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LP_PC    = ADDR_W'(PC_ADDR);

  // The PC has no storage slot; addresses above it shift down by one.
  logic [DATA_W-1:0] r_rf [0:NUM_REGS-2];

  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;
  logic              w_wr_ok;

  function automatic logic [ADDR_W-1:0] slot(input logic [ADDR_W-1:0] a);
    if (a == LP_PC) return '0;
    if (a > LP_PC)  return a - 1'b1;
    return a;
  endfunction

  assign w_wr_ok = bus.we3 && (bus.wa3 != LP_PC);

  // Storage: cleared on reset, written on we3 unless the target is the PC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS-1; i++) r_rf[i] <= '0;
    end else if (w_wr_ok) begin
      r_rf[slot(bus.wa3)] <= bus.wd3;
    end
  end

  // Read muxing: PC first, then write-through bypass, then storage.
  always_comb begin
    w_rd1 = r_rf[slot(bus.ra1)];
    w_rd2 = r_rf[slot(bus.ra2)];
    if (bus.ra1 == LP_PC)                  w_rd1 = bus.r15;
    else if (w_wr_ok && bus.wa3 == bus.ra1) w_rd1 = bus.wd3;
    if (bus.ra2 == LP_PC)                  w_rd2 = bus.r15;
    else if (w_wr_ok && bus.wa3 == bus.ra2) w_rd2 = bus.wd3;
  end

  assign bus.rd1 = w_rd1;
  assign bus.rd2 = w_rd2;

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .PC_ADDR (PC_ADDR)
  ) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_set_en   (bus.iss),
    .i_set_addr (bus.isa),
    .i_clr_en   (bus.we3),
    .i_clr_addr (bus.wa3),
    .i_ra1      (bus.ra1),
    .i_ra2      (bus.ra2),
    .o_rb1      (bus.rb1),
    .o_rb2      (bus.rb2),
    .o_pend_cnt (bus.pend_cnt)
  );

endmodule
